// File: rtl/instruction_cache.sv
// ---------------------------------------------------------------------------
// instruction_cache
//
// Direct-mapped, read-only instruction cache with 16-byte (4-word) lines.
// A hit returns the instruction combinationally in the same cycle.
// A miss stalls the CPU. It then fetches the whole block from instruction
// memory and refills the line. The fetch goes through a two-state FSM:
// IDLE and MEM_FETCH.
//
// Optional feature:
//   ICACHE_STATS_EN - when defined, the cache keeps saturating 16-bit
//                     hit/miss counters. When undefined, no counter
//                     registers exist and HIT_COUNT/MISS_COUNT read 0.
//
// Parameters:
//   NUM_BLOCKS   number of direct-mapped lines (power of two, 2..32)
//   ADDR_WIDTH   width of the CPU byte address
//
// Ports:
//   CLK           clock; all state changes on the rising edge
//   RESET         synchronous active-high reset
//   READ          CPU fetch request
//   ADDRESS       CPU byte address (PC); bits [1:0] are ignored
//   READDATA      fetched instruction word
//   BUSYWAIT      high while the CPU must stall
//   MEM_READ      block-read request to instruction memory
//   MEM_ADDRESS   block address {tag,index} of the outstanding fetch
//   MEM_READDATA  16-byte block returned by memory (word k at [32k+31:32k])
//   MEM_BUSYWAIT  high while memory is busy
//   HIT_COUNT     number of IDLE-cycle hits (saturating)
//   MISS_COUNT    number of misses issued to memory (saturating)
// ---------------------------------------------------------------------------
module instruction_cache #(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  output logic [31:0]           READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [ADDR_WIDTH-5:0] MEM_ADDRESS,
  input  logic [127:0]          MEM_READDATA,
  input  logic                  MEM_BUSYWAIT,
  output logic [15:0]           HIT_COUNT,
  output logic [15:0]           MISS_COUNT
);

  localparam int INDEX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W   = ADDR_WIDTH - 4 - INDEX_W;

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] MEM_FETCH = 1'b1;

  // Address fields of the current CPU request
  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;

  assign offset = ADDRESS[3:2];
  assign index  = ADDRESS[INDEX_W+3:4];
  assign tag    = ADDRESS[ADDR_WIDTH-1:INDEX_W+4];

  // The byte-lane bits never select anything: fetches are word aligned.
  logic unused_byte_bits;
  assign unused_byte_bits = ^ADDRESS[1:0];

  // Line storage. The data and tag arrays are not reset. A line is only
  // ever observed through its valid bit, so stale contents are harmless.
  logic [127:0]          data_mem [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_reg;

  logic [0:0]            state_reg, state_next;
  logic [ADDR_WIDTH-5:0] mem_address_reg, mem_address_next;

  // Refill target comes from the registered block address, never from
  // ADDRESS. The CPU is free to change ADDRESS while the fetch is pending.
  logic [INDEX_W-1:0]    fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic                  fill_en;
  logic [NUM_BLOCKS-1:0] fill_line_sel;

  assign fill_index = mem_address_reg[INDEX_W-1:0];
  assign fill_tag   = mem_address_reg[ADDR_WIDTH-5:INDEX_W];

  // Reset wins over a refill that completes on the same edge.
  assign fill_en = (state_reg == MEM_FETCH) && !MEM_BUSYWAIT && !RESET;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_line_sel
      assign fill_line_sel[gi] = (fill_index == INDEX_W'(gi));
    end
  endgenerate

  // Lookup of the indexed line
  logic [127:0] line_data;
  logic [31:0]  line_words [4];
  logic         line_valid;
  logic         lookup_hit;

  assign line_data  = data_mem[index];
  assign line_valid = valid_reg[index];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_word_split
      assign line_words[gi] = line_data[32*gi +: 32];
    end
  endgenerate

  assign lookup_hit = READ && line_valid && (tag_mem[index] == tag);

  // An invalid line reads as zero. This keeps READDATA clean after reset
  // without having to clear the data array.
  assign READDATA    = line_valid ? line_words[offset] : 32'd0;
  assign MEM_ADDRESS = mem_address_reg;

  // Control FSM
  logic hit_evt;
  logic miss_evt;

  always_comb begin
    state_next       = state_reg;
    mem_address_next = mem_address_reg;
    BUSYWAIT         = 1'b0;
    MEM_READ         = 1'b0;
    hit_evt          = 1'b0;
    miss_evt         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (READ && !lookup_hit) begin
          BUSYWAIT         = 1'b1;
          miss_evt         = 1'b1;
          mem_address_next = {tag, index};
          state_next       = MEM_FETCH;
        end else if (lookup_hit) begin
          hit_evt = 1'b1;
        end
      end
      MEM_FETCH: begin
        // Stall continues through the refill cycle. The hit is served from
        // IDLE on the following cycle.
        BUSYWAIT = 1'b1;
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg       <= IDLE;
      mem_address_reg <= '0;
      valid_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      mem_address_reg <= mem_address_next;
      if (fill_en) begin
        valid_reg <= valid_reg | fill_line_sel;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_en) begin
      data_mem[fill_index] <= MEM_READDATA;
      tag_mem[fill_index]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_reg;
  logic [15:0] miss_count_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count_reg  <= 16'd0;
      miss_count_reg <= 16'd0;
    end else begin
      if (hit_evt && (hit_count_reg != 16'hFFFF)) begin
        hit_count_reg <= hit_count_reg + 16'd1;
      end
      if (miss_evt && (miss_count_reg != 16'hFFFF)) begin
        miss_count_reg <= miss_count_reg + 16'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_count_reg;
  assign MISS_COUNT = miss_count_reg;
`else
  // Event strobes have no consumer without the statistics block.
  logic unused_stat_events;
  assign unused_stat_events = hit_evt ^ miss_evt;

  assign HIT_COUNT  = 16'd0;
  assign MISS_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// ---------------------------------------------------------------------------
// tb_instruction_cache
//
// Directed bench for instruction_cache with its default parameters
// (8 lines, 10-bit address). It uses a behavioural instruction memory.
// Word k of block b reads as {16'hC0DE, 2'b00, b, 6'b0, k}, so every
// expected instruction can be worked out by hand from the address.
// The counter expectations depend on whether ICACHE_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic         READ;
  logic [9:0]   ADDRESS;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;

`ifdef ICACHE_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  instruction_cache #(
    .NUM_BLOCKS (8),
    .ADDR_WIDTH (10)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .ADDRESS      (ADDRESS),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mk_word(input logic [5:0] blk, input logic [1:0] k);
    return {16'hC0DE, 2'b00, blk, 6'b000000, k};
  endfunction

  // Behavioural instruction memory
  always_comb begin
    MEM_READDATA = {mk_word(MEM_ADDRESS, 2'd3), mk_word(MEM_ADDRESS, 2'd2),
                    mk_word(MEM_ADDRESS, 2'd1), mk_word(MEM_ADDRESS, 2'd0)};
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check_val({tag, "_hits"},   32'(HIT_COUNT),  STATS_ON ? 32'(exp_hits)   : 32'd0);
    check_val({tag, "_misses"}, 32'(MISS_COUNT), STATS_ON ? 32'(exp_misses) : 32'd0);
  endtask

  // Full miss: an issue cycle, `busy` stalled memory cycles, then one
  // refill cycle. The task returns in IDLE with the line filled.
  task automatic do_miss(input logic [9:0] addr, input int busy, input logic [5:0] exp_blk);
    READ = 1'b1;
    ADDRESS = addr;
    MEM_BUSYWAIT = 1'b1;
    #1;
    check_val("issue_busywait", 32'(BUSYWAIT), 32'd1);
    check_val("issue_mem_read", 32'(MEM_READ), 32'd0);
    tick();
    exp_misses++;
    for (int i = 0; i < busy; i++) begin
      check_val("fetch_mem_read", 32'(MEM_READ), 32'd1);
      check_val("fetch_mem_addr", 32'(MEM_ADDRESS), 32'(exp_blk));
      check_val("fetch_busywait", 32'(BUSYWAIT), 32'd1);
      tick();
    end
    MEM_BUSYWAIT = 1'b0;
    #1;
    check_val("refill_mem_read", 32'(MEM_READ), 32'd1);
    check_val("refill_mem_addr", 32'(MEM_ADDRESS), 32'(exp_blk));
    tick();
    MEM_BUSYWAIT = 1'b1;
    $display("txn miss  addr=%h blk=%h busy=%0d", addr, exp_blk, busy);
  endtask

  task automatic do_hit(input logic [9:0] addr, input logic [31:0] exp_word);
    READ = 1'b1;
    ADDRESS = addr;
    #1;
    check_val("hit_busywait", 32'(BUSYWAIT), 32'd0);
    check_val("hit_mem_read", 32'(MEM_READ), 32'd0);
    check_val("hit_readdata", READDATA, exp_word);
    tick();
    exp_hits++;
    $display("txn hit   addr=%h data=%h", addr, READDATA);
  endtask

  initial begin
    RESET = 1'b1;
    READ = 1'b0;
    ADDRESS = 10'h000;
    MEM_BUSYWAIT = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    #1;
    check_val("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check_val("rst_mem_read", 32'(MEM_READ), 32'd0);
    check_val("rst_readdata", READDATA, 32'd0);
    check_val("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
    check_counters("rst");
    $display("txn reset");

    // Cold miss at 0x000 with four busy cycles, then sequential hits
    do_miss(10'h000, 4, 6'h00);
    do_hit(10'h000, mk_word(6'h00, 2'd0));
    do_hit(10'h004, mk_word(6'h00, 2'd1));
    do_hit(10'h008, mk_word(6'h00, 2'd2));
    do_hit(10'h00C, mk_word(6'h00, 2'd3));
    check_counters("seq");

    // Same index, tag 1: evicts block 0x00, so 0x000 misses again
    do_miss(10'h080, 1, 6'h08);
    do_hit(10'h080, mk_word(6'h08, 2'd0));
    do_miss(10'h000, 0, 6'h00);
    do_hit(10'h000, mk_word(6'h00, 2'd0));
    check_counters("conflict");

    // Address changes and READ drops while the fetch is pending
    READ = 1'b1;
    ADDRESS = 10'h100;
    MEM_BUSYWAIT = 1'b1;
    #1;
    check_val("chg_issue_busywait", 32'(BUSYWAIT), 32'd1);
    tick();
    exp_misses++;
    READ = 1'b0;
    ADDRESS = 10'h200;
    #1;
    check_val("chg_mem_read", 32'(MEM_READ), 32'd1);
    check_val("chg_mem_addr", 32'(MEM_ADDRESS), 32'h10);
    tick();
    check_val("chg_mem_addr_hold", 32'(MEM_ADDRESS), 32'h10);
    MEM_BUSYWAIT = 1'b0;
    tick();
    MEM_BUSYWAIT = 1'b1;
    #1;
    check_val("chg_idle_mem_read", 32'(MEM_READ), 32'd0);
    check_val("chg_idle_busywait", 32'(BUSYWAIT), 32'd0);
    $display("txn miss  addr=100 blk=10 (address moved, READ dropped)");
    do_hit(10'h100, mk_word(6'h10, 2'd0));
    do_hit(10'h104, mk_word(6'h10, 2'd1));

    // No request: indexed word visible, nothing issued, address held
    READ = 1'b0;
    ADDRESS = 10'h108;
    #1;
    check_val("noread_readdata", READDATA, mk_word(6'h10, 2'd2));
    check_val("noread_busywait", 32'(BUSYWAIT), 32'd0);
    check_val("noread_mem_read", 32'(MEM_READ), 32'd0);
    check_val("noread_mem_addr", 32'(MEM_ADDRESS), 32'h10);
    tick();
    check_counters("pre_abort");
    $display("txn idle  addr=108 data=%h", READDATA);

    // Reset during the fetch, coinciding with memory release: the fill is dropped
    READ = 1'b1;
    ADDRESS = 10'h040;
    MEM_BUSYWAIT = 1'b1;
    #1;
    tick();
    exp_misses++;
    check_val("abort_pre_mem_read", 32'(MEM_READ), 32'd1);
    check_val("abort_pre_mem_addr", 32'(MEM_ADDRESS), 32'h04);
    RESET = 1'b1;
    MEM_BUSYWAIT = 1'b0;
    tick();
    RESET = 1'b0;
    MEM_BUSYWAIT = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    #1;
    check_val("abort_mem_read", 32'(MEM_READ), 32'd0);
    check_val("abort_mem_addr", 32'(MEM_ADDRESS), 32'd0);
    check_val("abort_busywait", 32'(BUSYWAIT), 32'd1);
    check_val("abort_readdata", READDATA, 32'd0);
    check_counters("abort");
    $display("txn reset during fetch addr=040");

    do_miss(10'h040, 2, 6'h04);
    do_hit(10'h040, mk_word(6'h04, 2'd0));
    do_hit(10'h04C, mk_word(6'h04, 2'd3));
    READ = 1'b0;
    tick();
    check_counters("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
